pc_sequencer: RTL and testbench

//   Program-counter / fetch sequencer for the 8-bit core. Fetches one instruction per PC over a
//   req/gnt port, issues it to the datapath on a valid/ready handshake, and computes next PC.
//   For class-11 (condition) instructions it evaluates the 3-bit condition against reg3 and

---
 rtl/pc_sequencer_pkg.sv | 37 +++
 rtl/pc_sequencer_cond_eval.sv | 21 ++
 rtl/pc_sequencer.sv | 137 +++++++++++++
 tb/tb_pc_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types for the program-counter sequencer: FSM states, instruction classes and condition codes.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        ISSUE = 2'd3
    } state_t;

    // Instruction class lives in instr[7:6].
    typedef enum logic [1:0] {
        CLS_IMM  = 2'b00,
        CLS_CALC = 2'b01,
        CLS_COPY = 2'b10,
        CLS_COND = 2'b11
    } cls_t;

    // Condition codes live in instr[2:0]; bit 2 inverts the sense of bits 1:0.
    typedef enum logic [2:0] {
        CC_NEVER  = 3'd0,
        CC_EQ     = 3'd1,
        CC_LT     = 3'd2,
        CC_LE     = 3'd3,
        CC_ALWAYS = 3'd4,
        CC_NE     = 3'd5,
        CC_GE     = 3'd6,
        CC_GT     = 3'd7
    } cond_t;

    function automatic cls_t instr_class(input logic [7:0] instr);
        return cls_t'(instr[7:6]);
    endfunction

endpackage

// File: rtl/pc_sequencer_cond_eval.sv
// Evaluates a 3-bit branch condition against an 8-bit signed operand.
// Latency: purely combinational, 0 cycles.
// Backpressure: none.
// Ports: operand (reg3 value), code (condition code) -> taken.
module cond_eval
    import pc_seq_pkg::*;
(
    input  logic [7:0] operand,
    input  logic [2:0] code,
    output logic       taken
);

    logic zero;
    logic neg;

    assign zero  = (operand == 8'h00);
    assign neg   = operand[7];
    // Bits 1:0 select EQ/LT (both = LE); bit 2 inverts, giving NEVER/ALWAYS/NE/GE/GT.
    assign taken = ((code[0] & zero) | (code[1] & neg)) ^ code[2];

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/issue sequencer: fetches one instruction per PC over req/gnt, issues it on valid/ready,
// and advances or branches the PC. Latency: 2 cycles per instruction minimum (FETCH+ISSUE).
// Backpressure: issue_vld holds with stable issue_instr until issue_rdy; no fetch while issuing.
// Optional feature: define PC_BRANCH_CNT_EN to add the saturating taken_cnt output.
// Ports: clk/rst (async active-low), run; fetch_req/fetch_addr/fetch_gnt/instr_in/instr_vld;
//        reg0 (jump target), reg3 (condition operand); issue_instr/issue_vld/issue_rdy;
//        pc, branch_taken [, taken_cnt].
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int PC_W     = 8,
    parameter int RESET_PC = 0,
    parameter int CNT_W    = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    output logic            fetch_req,
    output logic [PC_W-1:0] fetch_addr,
    input  logic            fetch_gnt,
    input  logic [7:0]      instr_in,
    input  logic            instr_vld,
    input  logic [7:0]      reg0,
    input  logic [7:0]      reg3,
    output logic [7:0]      issue_instr,
    output logic            issue_vld,
    input  logic            issue_rdy,
    output logic [PC_W-1:0] pc,
    output logic            branch_taken
`ifdef PC_BRANCH_CNT_EN
    ,
    output logic [CNT_W-1:0] taken_cnt
`endif
);

    if (PC_W < 1 || CNT_W < 1) begin : g_param_check
        $error("pc_sequencer: PC_W and CNT_W must be at least 1");
    end

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc_nxt;
    logic [7:0]      instr_q;
    logic            latch;
    logic            accept;
    logic            cond_true;
    logic            is_cond;
    logic            take_branch;
    logic [PC_W-1:0] jump_tgt;

    cond_eval u_cond_eval (
        .operand (reg3),
        .code    (instr_q[2:0]),
        .taken   (cond_true)
    );

    assign is_cond     = (instr_class(instr_q) == CLS_COND);
    assign take_branch = accept & is_cond & cond_true;
    assign jump_tgt    = PC_W'(reg0);

    assign fetch_addr  = pc;
    assign issue_instr = instr_q;

    always_comb begin
        state_nxt = state;
        fetch_req = 1'b0;
        issue_vld = 1'b0;
        latch     = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (run) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                fetch_req = 1'b1;
                if (fetch_gnt) begin
                    if (instr_vld) begin
                        latch     = 1'b1;
                        state_nxt = ISSUE;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (instr_vld) begin
                    latch     = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                issue_vld = 1'b1;
                if (issue_rdy) begin
                    accept    = 1'b1;
                    // run only gates new fetches; the accepted instruction always completes.
                    state_nxt = run ? FETCH : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pc_nxt = pc;
        if (accept) begin
            pc_nxt = take_branch ? jump_tgt : pc + PC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            pc           <= PC_W'(RESET_PC);
            instr_q      <= 8'h00;
            branch_taken <= 1'b0;
        end else begin
            state        <= state_nxt;
            pc           <= pc_nxt;
            branch_taken <= take_branch;
            if (latch) begin
                instr_q <= instr_in;
            end
        end
    end

`ifdef PC_BRANCH_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            taken_cnt <= '0;
        end else if (take_branch && (taken_cnt != {CNT_W{1'b1}})) begin
            taken_cnt <= taken_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized bench for pc_sequencer with a condition-table reference model.
// Inputs are driven and outputs sampled on the falling edge; the DUT samples on the rising edge.
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       run = 1'b0;
    logic       fetch_gnt = 1'b0;
    logic       instr_vld = 1'b0;
    logic       issue_rdy = 1'b0;
    logic [7:0] instr_in = 8'h00;
    logic [7:0] reg0 = 8'h00;
    logic [7:0] reg3 = 8'h00;
    logic       fetch_req;
    logic [7:0] fetch_addr;
    logic [7:0] issue_instr;
    logic       issue_vld;
    logic [7:0] pc;
    logic       branch_taken;
`ifdef PC_BRANCH_CNT_EN
    logic [15:0] taken_cnt;
`endif

    int         n_assert = 0;
    int         n_fail = 0;
    logic [7:0] m_pc = 8'h00;
    int         m_cnt = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.PC_W(8), .RESET_PC(0), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .fetch_req    (fetch_req),
        .fetch_addr   (fetch_addr),
        .fetch_gnt    (fetch_gnt),
        .instr_in     (instr_in),
        .instr_vld    (instr_vld),
        .reg0         (reg0),
        .reg3         (reg3),
        .issue_instr  (issue_instr),
        .issue_vld    (issue_vld),
        .issue_rdy    (issue_rdy),
        .pc           (pc),
        .branch_taken (branch_taken)
`ifdef PC_BRANCH_CNT_EN
        ,
        .taken_cnt    (taken_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Branch decision straight from the condition table, using signed reg3.
    function automatic bit ref_taken(input logic [7:0] ins, input logic [7:0] r3);
        logic signed [7:0] s;
        s = r3;
        if (ins[7:6] != 2'b11) return 1'b0;
        case (ins[2:0])
            3'd0:    return 1'b0;
            3'd1:    return s == 0;
            3'd2:    return s < 0;
            3'd3:    return s <= 0;
            3'd4:    return 1'b1;
            3'd5:    return s != 0;
            3'd6:    return s >= 0;
            default: return s > 0;
        endcase
    endfunction

    // Starts at a falling edge with the DUT in FETCH; ends at the falling edge after accept.
    // gd: cycles without grant, vd: cycles between grant and data, rd: cycles without ready.
    task automatic do_instr(input logic [7:0] ins, input int gd, input int vd, input int rd,
                            input logic [7:0] r0, input logic [7:0] r3);
        bit tk;
        chk("fetch_req_in_fetch", 32'(fetch_req), 32'(1));
        chk("fetch_addr", 32'(fetch_addr), 32'(m_pc));
        for (int i = 0; i < gd; i++) begin
            fetch_gnt = 1'b0;
            instr_vld = 1'($urandom);   // must be ignored without grant
            instr_in  = 8'($urandom);
            @(negedge clk);
            chk("fetch_addr_stable", 32'(fetch_addr), 32'(m_pc));
            chk("fetch_req_held", 32'(fetch_req), 32'(1));
        end
        fetch_gnt = 1'b1;
        instr_vld = (vd == 0);
        instr_in  = (vd == 0) ? ins : 8'($urandom);
        @(negedge clk);
        fetch_gnt = 1'b0;
        for (int i = 0; i < vd; i++) begin
            chk("wait_no_req", 32'(fetch_req), 32'(0));
            chk("wait_no_issue", 32'(issue_vld), 32'(0));
            instr_vld = (i == vd - 1);
            instr_in  = (i == vd - 1) ? ins : 8'($urandom);
            @(negedge clk);
        end
        for (int i = 0; i < rd; i++) begin
            instr_vld = 1'($urandom);   // stray data during ISSUE must not disturb the held instr
            instr_in  = 8'($urandom);
            issue_rdy = 1'b0;
            reg0      = 8'($urandom);
            reg3      = 8'($urandom);
            chk("stall_issue_vld", 32'(issue_vld), 32'(1));
            chk("stall_issue_instr", 32'(issue_instr), 32'(ins));
            chk("stall_pc", 32'(pc), 32'(m_pc));
            chk("stall_no_req", 32'(fetch_req), 32'(0));
            @(negedge clk);
        end
        instr_vld = 1'b0;
        chk("issue_vld", 32'(issue_vld), 32'(1));
        chk("issue_instr", 32'(issue_instr), 32'(ins));
        chk("no_pulse_in_issue", 32'(branch_taken), 32'(0));
        issue_rdy = 1'b1;
        reg0      = r0;
        reg3      = r3;
        @(negedge clk);
        issue_rdy = 1'b0;
        tk   = ref_taken(ins, r3);
        m_pc = tk ? r0 : m_pc + 8'd1;
        if (tk && m_cnt < 65535) m_cnt++;
        chk("pc_after_accept", 32'(pc), 32'(m_pc));
        chk("branch_taken", 32'(branch_taken), 32'(tk));
        chk("issue_vld_drop", 32'(issue_vld), 32'(0));
        chk("next_state_req", 32'(fetch_req), 32'(run));
`ifdef PC_BRANCH_CNT_EN
        chk("taken_cnt", 32'(taken_cnt), 32'(m_cnt));
`endif
    endtask

    initial begin
        logic [7:0] ins;
        logic [7:0] r3;

        // Reset values.
        #1;
        chk("rst_pc", 32'(pc), 32'(0));
        chk("rst_fetch_req", 32'(fetch_req), 32'(0));
        chk("rst_issue_vld", 32'(issue_vld), 32'(0));
        chk("rst_issue_instr", 32'(issue_instr), 32'(0));
        chk("rst_branch_taken", 32'(branch_taken), 32'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_no_req", 32'(fetch_req), 32'(0));
        run = 1'b1;
        @(negedge clk);
        chk("start_req", 32'(fetch_req), 32'(1));

        // Reset asserted while in ISSUE aborts everything.
        fetch_gnt = 1'b1;
        instr_vld = 1'b1;
        instr_in  = 8'h41;
        @(negedge clk);
        fetch_gnt = 1'b0;
        instr_vld = 1'b0;
        chk("pre_abort_issue", 32'(issue_vld), 32'(1));
        #2 rst = 1'b0;
        #1;
        chk("abort_pc", 32'(pc), 32'(0));
        chk("abort_issue_vld", 32'(issue_vld), 32'(0));
        chk("abort_fetch_req", 32'(fetch_req), 32'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("restart_req", 32'(fetch_req), 32'(1));
        chk("restart_addr", 32'(fetch_addr), 32'(0));
        m_pc = 8'h00;
        m_cnt = 0;

        // Back-to-back sequential instructions, 2 cycles each.
        repeat (3) do_instr(8'h00, 0, 0, 0, 8'h00, 8'h00);

        // Branch taken / not taken.
        do_instr(8'hC1, 0, 0, 0, 8'h40, 8'h00);
        do_instr(8'hC1, 0, 0, 0, 8'h99, 8'h05);

        // Condition sweep.
        do_instr(8'hC3, 0, 0, 0, 8'h10, 8'h80);
        do_instr(8'hC7, 0, 0, 0, 8'h20, 8'h01);
        do_instr(8'hC7, 0, 0, 0, 8'h30, 8'h00);
        do_instr(8'hC4, 0, 0, 0, 8'h50, 8'h7F);
        do_instr(8'hC0, 0, 0, 0, 8'h60, 8'h00);

        // Datapath stall for 5 cycles, with grant and data delays.
        do_instr(8'h85, 2, 3, 5, 8'h00, 8'h00);

        // Wrap 0xFF -> 0x00.
        do_instr(8'hC4, 0, 0, 0, 8'hFF, 8'h00);
        do_instr(8'h41, 0, 0, 0, 8'h12, 8'h00);

        // run dropped: current instruction completes, then the sequencer idles.
        run = 1'b0;
        do_instr(8'h13, 1, 1, 1, 8'h00, 8'h00);
        repeat (3) begin
            @(negedge clk);
            chk("idle_hold_req", 32'(fetch_req), 32'(0));
            chk("idle_hold_pc", 32'(pc), 32'(m_pc));
        end
        run = 1'b1;
        @(negedge clk);

        // Randomized traffic.
        for (int k = 0; k < 60; k++) begin
            ins = 8'($urandom);
            if ($urandom_range(1, 0) == 1) ins[7:6] = 2'b11;
            case ($urandom_range(2, 0))
                0:       r3 = 8'h00;
                1:       r3 = 8'h80 | 8'($urandom);
                default: r3 = 8'($urandom);
            endcase
            do_instr(ins, $urandom_range(2, 0), $urandom_range(2, 0), $urandom_range(3, 0),
                     8'($urandom), r3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
